// File: rtl/csi2_packet_decoder.sv
// rtl/csi2_packet_decoder.sv - CSI-2 packet decoder (header ECC, payload packing); CSI2_CRC_CHECK_EN enables payload CRC check
module csi2_packet_decoder #(
   parameter int NUM_LANES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [8*NUM_LANES-1:0] lane_byte,
   input  logic                   lane_byte_valid,
   output logic [1:0]             virtual_channel,
   output logic [5:0]             image_data_type,
   output logic [15:0]            word_count,
   output logic                   header_valid,
   output logic [31:0]            image_data,
   output logic                   image_data_enable,
   output logic [3:0]             image_data_byte_enable,
   output logic                   image_data_last,
   output logic                   packet_error,
   output logic                   crc_error
);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FOOTER, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        valid_prev_q, valid_prev_d;
   logic [23:0] hdr_q, hdr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] rem_q, rem_d;
   logic [1:0]  widx_q, widx_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  vc_q, vc_d;
   logic [5:0]  dt_q, dt_d;
   logic [15:0] wc_q, wc_d;
   logic        hv_q, hv_d;
   logic [31:0] data_q, data_d;
   logic        den_q, den_d;
   logic [3:0]  dbe_q, dbe_d;
   logic        dlast_q, dlast_d;
   logic        perr_q, perr_d;
`ifdef CSI2_CRC_CHECK_EN
   logic [15:0] crc_q, crc_d;
   logic [7:0]  crc_rx_q, crc_rx_d;
   logic        cerr_q, cerr_d;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      end
      return r;
   endfunction
`endif

   // Each parity bit is the XOR of the header data bits selected by its mask.
   function automatic logic [5:0] calc_ecc(input logic [23:0] d);
      return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
              ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         valid_prev_q <= 1'b1;
         hdr_q        <= '0;
         cnt_q        <= '0;
         rem_q        <= '0;
         widx_q       <= '0;
         word_q       <= '0;
         vc_q         <= '0;
         dt_q         <= '0;
         wc_q         <= '0;
         hv_q         <= 1'b0;
         data_q       <= '0;
         den_q        <= 1'b0;
         dbe_q        <= '0;
         dlast_q      <= 1'b0;
         perr_q       <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
         crc_q        <= 16'hFFFF;
         crc_rx_q     <= '0;
         cerr_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         valid_prev_q <= valid_prev_d;
         hdr_q        <= hdr_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         widx_q       <= widx_d;
         word_q       <= word_d;
         vc_q         <= vc_d;
         dt_q         <= dt_d;
         wc_q         <= wc_d;
         hv_q         <= hv_d;
         data_q       <= data_d;
         den_q        <= den_d;
         dbe_q        <= dbe_d;
         dlast_q      <= dlast_d;
         perr_q       <= perr_d;
`ifdef CSI2_CRC_CHECK_EN
         crc_q        <= crc_d;
         crc_rx_q     <= crc_rx_d;
         cerr_q       <= cerr_d;
`endif
      end
   end

   always_comb begin
      logic [7:0] b;
      b            = '0;
      state_d      = state_q;
      valid_prev_d = lane_byte_valid;
      hdr_d        = hdr_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      widx_d       = widx_q;
      word_d       = word_q;
      vc_d         = vc_q;
      dt_d         = dt_q;
      wc_d         = wc_q;
      hv_d         = 1'b0;
      data_d       = data_q;
      den_d        = 1'b0;
      dbe_d        = '0;
      dlast_d      = 1'b0;
      perr_d       = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      crc_d        = crc_q;
      crc_rx_d     = crc_rx_q;
      cerr_d       = 1'b0;
`endif
      if (!lane_byte_valid) begin
         if (state_q inside {HEADER, PAYLOAD, FOOTER}) perr_d = 1'b1;
         state_d = IDLE;
         word_d  = '0;
         widx_d  = '0;
      end else begin
         if (state_q == IDLE && !valid_prev_q) begin
            state_d = HEADER;
            cnt_d   = '0;
            word_d  = '0;
            widx_d  = '0;
         end
         // Lanes are walked in packet order so state changes take effect mid-cycle.
         for (int k = 0; k < NUM_LANES; k++) begin
            b = lane_byte[8*k +: 8];
            case (state_d)
               HEADER: begin
                  if (cnt_d == 2'd3) begin
                     cnt_d = '0;
                     if (calc_ecc(hdr_d) == b[5:0]) begin
                        hv_d = 1'b1;
                        vc_d = hdr_d[7:6];
                        dt_d = hdr_d[5:0];
                        wc_d = hdr_d[23:8];
                        rem_d = hdr_d[23:8];
`ifdef CSI2_CRC_CHECK_EN
                        crc_d = 16'hFFFF;
`endif
                        if (hdr_d[5:4] == 2'b00)       state_d = DRAIN;
                        else if (hdr_d[23:8] == 16'd0) state_d = FOOTER;
                        else                           state_d = PAYLOAD;
                     end else begin
                        perr_d  = 1'b1;
                        state_d = DRAIN;
                     end
                  end else begin
                     hdr_d[8*cnt_d +: 8] = b;
                     cnt_d = cnt_d + 2'd1;
                  end
               end
               PAYLOAD: begin
                  word_d[8*widx_d +: 8] = b;
                  rem_d = rem_d - 16'd1;
`ifdef CSI2_CRC_CHECK_EN
                  crc_d = crc_byte(crc_d, b);
`endif
                  if (widx_d == 2'd3 || rem_d == 16'd0) begin
                     data_d  = word_d;
                     den_d   = 1'b1;
                     dbe_d   = {widx_d == 2'd3, widx_d >= 2'd2, widx_d >= 2'd1, 1'b1};
                     dlast_d = (rem_d == 16'd0);
                     word_d  = '0;
                     widx_d  = '0;
                  end else begin
                     widx_d = widx_d + 2'd1;
                  end
                  if (rem_d == 16'd0) state_d = FOOTER;
               end
               FOOTER: begin
                  if (cnt_d == 2'd0) begin
`ifdef CSI2_CRC_CHECK_EN
                     crc_rx_d = b;
`endif
                     cnt_d = 2'd1;
                  end else begin
`ifdef CSI2_CRC_CHECK_EN
                     cerr_d = ({b, crc_rx_d} != crc_d);
`endif
                     state_d = DRAIN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      virtual_channel        = vc_q;
      image_data_type        = dt_q;
      word_count             = wc_q;
      header_valid           = hv_q;
      image_data             = data_q;
      image_data_enable      = den_q;
      image_data_byte_enable = dbe_q;
      image_data_last        = dlast_q;
      packet_error           = perr_q;
`ifdef CSI2_CRC_CHECK_EN
      crc_error              = cerr_q;
`else
      crc_error              = 1'b0;
`endif
   end

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// tb/tb_csi2_packet_decoder.sv - directed bench for csi2_packet_decoder at 1, 2 and 4 lanes
module tb_csi2_packet_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] lb;
   logic        v1, v2, v4;

   logic [1:0]  vc   [3];
   logic [5:0]  dt   [3];
   logic [15:0] wc   [3];
   logic        hv   [3];
   logic [31:0] idat [3];
   logic        ide  [3];
   logic [3:0]  ibe  [3];
   logic        ilst [3];
   logic        pe   [3];
   logic        ce   [3];

   always #5 clk = ~clk;

   csi2_packet_decoder #(.NUM_LANES(1)) u1 (
      .clock(clk), .reset(rst_n), .lane_byte(lb[7:0]), .lane_byte_valid(v1),
      .virtual_channel(vc[0]), .image_data_type(dt[0]), .word_count(wc[0]),
      .header_valid(hv[0]), .image_data(idat[0]), .image_data_enable(ide[0]),
      .image_data_byte_enable(ibe[0]), .image_data_last(ilst[0]),
      .packet_error(pe[0]), .crc_error(ce[0]));

   csi2_packet_decoder #(.NUM_LANES(2)) u2 (
      .clock(clk), .reset(rst_n), .lane_byte(lb[15:0]), .lane_byte_valid(v2),
      .virtual_channel(vc[1]), .image_data_type(dt[1]), .word_count(wc[1]),
      .header_valid(hv[1]), .image_data(idat[1]), .image_data_enable(ide[1]),
      .image_data_byte_enable(ibe[1]), .image_data_last(ilst[1]),
      .packet_error(pe[1]), .crc_error(ce[1]));

   csi2_packet_decoder #(.NUM_LANES(4)) u4 (
      .clock(clk), .reset(rst_n), .lane_byte(lb[31:0]), .lane_byte_valid(v4),
      .virtual_channel(vc[2]), .image_data_type(dt[2]), .word_count(wc[2]),
      .header_valid(hv[2]), .image_data(idat[2]), .image_data_enable(ide[2]),
      .image_data_byte_enable(ibe[2]), .image_data_last(ilst[2]),
      .packet_error(pe[2]), .crc_error(ce[2]));

   int          n_tests = 0;
   int          n_fail  = 0;
   int          sel     = 1;
   logic [7:0]  pkt [64];
   int          plen;

   int          n_hv = 0, n_w = 0, n_pe = 0, n_ce = 0;
   logic [1:0]  m_vc;
   logic [5:0]  m_dt;
   logic [15:0] m_wc;
   logic [31:0] w_data [64];
   logic [3:0]  w_be   [64];
   logic        w_last [64];
   int          b_hv, b_w, b_pe, b_ce;

   always @(negedge clk) begin
      if (hv[sel]) begin
         n_hv++;
         m_vc = vc[sel];
         m_dt = dt[sel];
         m_wc = wc[sel];
      end
      if (ide[sel] && n_w < 64) begin
         w_data[n_w] = idat[sel];
         w_be[n_w]   = ibe[sel];
         w_last[n_w] = ilst[sel];
         n_w++;
      end
      if (pe[sel]) n_pe++;
      if (ce[sel]) n_ce++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

   function automatic logic [15:0] crcb(input logic [15:0] c, input logic [7:0] d);
      logic       fb;
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[15:1]};
         if (fb) r = r ^ 16'h8408;
      end
      return r;
   endfunction

   task automatic mk_pkt(input logic [1:0] pvc, input logic [5:0] pdt, input logic [15:0] pwc,
                         input logic [7:0] start);
      logic [15:0] crc;
      pkt[0] = {pvc, pdt};
      pkt[1] = pwc[7:0];
      pkt[2] = pwc[15:8];
      pkt[3] = {2'b00, ecc({pkt[2], pkt[1], pkt[0]})};
      if (pdt < 6'h10) begin
         plen = 4;
      end else begin
         crc = 16'hFFFF;
         for (int i = 0; i < int'(pwc); i++) begin
            pkt[4+i] = start + 8'(i);
            crc = crcb(crc, pkt[4+i]);
         end
         pkt[4+int'(pwc)] = crc[7:0];
         pkt[5+int'(pwc)] = crc[15:8];
         plen = 6 + int'(pwc);
      end
   endtask

   task automatic drive(input int nl, input int start, input int ncyc);
      int idx;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         lb = '0;
         for (int l = 0; l < nl; l++) begin
            idx = start + c*nl + l;
            if (idx < plen) lb[8*l +: 8] = pkt[idx];
         end
         v1 = (nl == 1);
         v2 = (nl == 2);
         v4 = (nl == 4);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      v1 = 1'b0; v2 = 1'b0; v4 = 1'b0; lb = '0;
      repeat (n - 1) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_hv = n_hv; b_w = n_w; b_pe = n_pe; b_ce = n_ce;
   endtask

   task automatic send(input int nl);
      sel = (nl == 1) ? 0 : (nl == 2) ? 1 : 2;
      snap();
      drive(nl, 0, (plen + nl - 1) / nl);
      idle(4);
   endtask

   task automatic check_037(input string tag);
      check({tag, "_hv"}, 32'(n_hv - b_hv), 1);
      check({tag, "_fields"}, {8'h0, m_vc, m_dt, m_wc}, {8'h0, 2'd1, 6'h2A, 16'd6});
      check({tag, "_nw"}, 32'(n_w - b_w), 2);
      check({tag, "_w0"}, w_data[b_w], 32'h04030201);
      check({tag, "_w0be"}, {27'h0, w_be[b_w], w_last[b_w]}, {27'h0, 4'hF, 1'b0});
      check({tag, "_w1"}, w_data[b_w+1], 32'h00000605);
      check({tag, "_w1be"}, {27'h0, w_be[b_w+1], w_last[b_w+1]}, {27'h0, 4'h3, 1'b1});
      check({tag, "_err"}, 32'(n_pe - b_pe + n_ce - b_ce), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; lb = '0; v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fields", {8'h0, vc[1], dt[1], wc[1]}, 32'h0);
      check("rst_data", idat[1], 32'h0);
      check("rst_pulses", {22'h0, hv[1], ide[1], ibe[1], ilst[1], pe[1], ce[1]}, 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Short packet, all-zero header
      mk_pkt(2'd0, 6'h00, 16'h0000, 8'h00);
      send(2);
      check("short_hv", 32'(n_hv - b_hv), 1);
      check("short_fields", {8'h0, m_vc, m_dt, m_wc}, 32'h0);
      check("short_nw", 32'(n_w - b_w), 0);
      check("short_pe", 32'(n_pe - b_pe), 0);

      // Bad ECC, then recovery with a short packet carrying data
      pkt[0] = 8'h00; pkt[1] = 8'h00; pkt[2] = 8'h00; pkt[3] = 8'h01; plen = 4;
      send(2);
      check("badecc_pe", 32'(n_pe - b_pe), 1);
      check("badecc_hv", 32'(n_hv - b_hv), 0);
      mk_pkt(2'd2, 6'h01, 16'h1234, 8'h00);
      send(2);
      check("recov_hv", 32'(n_hv - b_hv), 1);
      check("recov_fields", {8'h0, m_vc, m_dt, m_wc}, {8'h0, 2'd2, 6'h01, 16'h1234});
      check("recov_pe", 32'(n_pe - b_pe), 0);

      // Long packet on every lane count
      mk_pkt(2'd1, 6'h2A, 16'd6, 8'h01);
      send(1); check_037("l1");
      send(2); check_037("l2");
      send(4); check_037("l4");

      // Corrupted CRC still emits payload
      mk_pkt(2'd1, 6'h2A, 16'd6, 8'h01);
      pkt[plen-2] = pkt[plen-2] ^ 8'h01;
      send(2);
      check("crcbad_nw", 32'(n_w - b_w), 2);
`ifdef CSI2_CRC_CHECK_EN
      check("crcbad_ce", 32'(n_ce - b_ce), 1);
`else
      check("crcbad_ce", 32'(n_ce - b_ce), 0);
`endif

      // WC=0 long packet goes straight to the footer
      mk_pkt(2'd3, 6'h2B, 16'd0, 8'h00);
      send(2);
      check("wc0_hv", 32'(n_hv - b_hv), 1);
      check("wc0_fields", {8'h0, m_vc, m_dt, m_wc}, {8'h0, 2'd3, 6'h2B, 16'd0});
      check("wc0_nw", 32'(n_w - b_w), 0);
      check("wc0_err", 32'(n_pe - b_pe + n_ce - b_ce), 0);

      // WC=5 leaves a single-byte final word
      mk_pkt(2'd0, 6'h24, 16'd5, 8'hA0);
      send(2);
      check("wc5_nw", 32'(n_w - b_w), 2);
      check("wc5_w0", w_data[b_w], 32'hA3A2A1A0);
      check("wc5_w1", w_data[b_w+1], 32'h000000A4);
      check("wc5_w1be", {27'h0, w_be[b_w+1], w_last[b_w+1]}, {27'h0, 4'h1, 1'b1});

      // Truncation after one payload word at 4 lanes
      mk_pkt(2'd1, 6'h2A, 16'd8, 8'h10);
      sel = 2; snap();
      drive(4, 0, 2);
      idle(4);
      check("trunc_pe", 32'(n_pe - b_pe), 1);
      check("trunc_nw", 32'(n_w - b_w), 1);
      check("trunc_w0", {w_data[b_w][31:1], w_last[b_w]}, {31'h09890888, 1'b0});
      check("trunc_hold_wc", {16'h0, wc[2]}, 32'd8);

      // Reset mid-payload, leftover bytes ignored, next packet decodes
      mk_pkt(2'd1, 6'h2A, 16'd8, 8'h10);
      sel = 1;
      drive(2, 0, 3);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_fields", {8'h0, vc[1], dt[1], wc[1]}, 32'h0);
      check("midrst_data", idat[1], 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      snap();
      drive(2, 6, 4);
      idle(4);
      check("midrst_ignored", 32'(n_hv - b_hv + n_w - b_w + n_pe - b_pe), 0);
      mk_pkt(2'd1, 6'h2A, 16'd6, 8'h01);
      send(2);
      check_037("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
